csr_regfile: RTL

Machine-mode CSR register file: the responder on the CSR request port driven by the exception unit. Each cycle it serves one combinational read and at most one write, set or clear. It maintains the trap CSRs (mstatus, mepc, mcause, mtvec and the others listed below) and the 64-bit mcycle and minstret counters. It also exports the status and vector values the pipeline and exception unit consume directly.

---
 rtl/csr_regfile_if.sv | 31 +++
 rtl/csr_regfile.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile_if.sv
// CSR request port between the exception unit (master) and the CSR register file (slave).
// One combinational read and at most one write/set/clear per cycle.
interface csr_regfile_if;
  logic        csr_w;
  logic [1:0]  csr_wsc_mode;
  logic [11:0] raddr;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_invalid;

  modport master (
    output csr_w,
    output csr_wsc_mode,
    output raddr,
    output waddr,
    output wdata,
    input  rdata,
    input  addr_invalid
  );

  modport slave (
    input  csr_w,
    input  csr_wsc_mode,
    input  raddr,
    input  waddr,
    input  wdata,
    output rdata,
    output addr_invalid
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap CSRs, 64-bit mcycle/minstret counters,
// combinational read port and a single write/set/clear port.
module csr_regfile #(
  parameter logic [31:0] HARTID   = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic                clk,
  input  logic                rst,
  csr_regfile_if.slave        csr,
  output logic [31:0]         mstatus,
  output logic [31:0]         mtvec_out,
  output logic [31:0]         mepc_out,
  input  logic                inst_retire,
  input  logic                ext_irq,
  output logic                irq_pending
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_SET   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // Only the writable bits are stored; constant fields are rebuilt on read.
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic        mie_mtie_q,     mie_mtie_d;
  logic        mie_msie_q,     mie_msie_d;
  logic [29:0] mtvec_q,        mtvec_d;
  logic [29:0] mepc_q,         mepc_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [31:0] mcause_q,       mcause_d;
  logic [31:0] mtval_q,        mtval_d;
  logic [63:0] mcycle_q,       mcycle_d;
  logic [63:0] minstret_q,     minstret_d;

  logic [31:0] mstatus_val;
  logic [31:0] mie_val;
  logic [31:0] mip_val;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mie_val     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0};
  assign mip_val     = {20'b0, ext_irq, 11'b0};

  assign mstatus     = mstatus_val;
  assign mtvec_out   = {mtvec_q, 2'b00};
  assign mepc_out    = {mepc_q, 2'b00};
  assign irq_pending = mstatus_mie_q & mie_meie_q & ext_irq;

  // Shared decoder for the read port and the old value of set/clear: {invalid, data}.
  function automatic logic [32:0] csr_lookup(input logic [11:0] addr);
    logic [32:0] res;
    res = {1'b0, 32'd0};
    unique case (addr)
      ADDR_MSTATUS:                 res[31:0] = mstatus_val;
      ADDR_MISA:                    res[31:0] = MISA_VAL;
      ADDR_MIE:                     res[31:0] = mie_val;
      ADDR_MTVEC:                   res[31:0] = {mtvec_q, 2'b00};
      ADDR_MSCRATCH:                res[31:0] = mscratch_q;
      ADDR_MEPC:                    res[31:0] = {mepc_q, 2'b00};
      ADDR_MCAUSE:                  res[31:0] = mcause_q;
      ADDR_MTVAL:                   res[31:0] = mtval_q;
      ADDR_MIP:                     res[31:0] = mip_val;
      ADDR_MCYCLE,   ADDR_CYCLE:    res[31:0] = mcycle_q[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   res[31:0] = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  res[31:0] = minstret_q[31:0];
      ADDR_MINSTRETH,ADDR_INSTRETH: res[31:0] = minstret_q[63:32];
      ADDR_MHARTID:                 res[31:0] = HARTID;
      default:                      res[32]   = 1'b1;
    endcase
    return res;
  endfunction

  logic [32:0] rd_lookup;
  logic [32:0] wr_lookup;
  logic        wr_writable;
  logic        wr_en;
  logic [31:0] wr_val;

  always_comb begin
    rd_lookup        = csr_lookup(csr.raddr);
    csr.rdata        = rd_lookup[31:0];
    csr.addr_invalid = rd_lookup[32];
  end

  // Decode the write target and build the pre-mask value from the read-masked old value.
  always_comb begin
    wr_lookup = csr_lookup(csr.waddr);
    unique case (csr.waddr)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MTVAL, ADDR_MCYCLE, ADDR_MCYCLEH,
      ADDR_MINSTRET, ADDR_MINSTRETH: wr_writable = 1'b1;
      default:                       wr_writable = 1'b0;
    endcase
    wr_en = csr.csr_w && (csr.csr_wsc_mode != 2'b00) && wr_writable && !wr_lookup[32];
    unique case (csr.csr_wsc_mode)
      MODE_WRITE: wr_val = csr.wdata;
      MODE_SET:   wr_val = wr_lookup[31:0] | csr.wdata;
      MODE_CLEAR: wr_val = wr_lookup[31:0] & ~csr.wdata;
      default:    wr_val = wr_lookup[31:0];
    endcase
  end

  // Next-state: counters free-run unless their own word is being written this cycle.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_msie_d     = mie_msie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mscratch_d     = mscratch_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'b0, inst_retire};

    if (wr_en) begin
      unique case (csr.waddr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wr_val[3];
          mstatus_mpie_d = wr_val[7];
        end
        ADDR_MIE: begin
          mie_meie_d = wr_val[11];
          mie_mtie_d = wr_val[7];
          mie_msie_d = wr_val[3];
        end
        ADDR_MTVEC:     mtvec_d    = wr_val[31:2];
        ADDR_MSCRATCH:  mscratch_d = wr_val;
        ADDR_MEPC:      mepc_d     = wr_val[31:2];
        ADDR_MCAUSE:    mcause_d   = wr_val;
        ADDR_MTVAL:     mtval_d    = wr_val;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_val};
        ADDR_MCYCLEH:   mcycle_d   = {wr_val, mcycle_q[31:0] + 32'd1};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wr_val};
        ADDR_MINSTRETH: minstret_d = {wr_val, minstret_q[31:0] + {31'b0, inst_retire}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_msie_q     <= 1'b0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mscratch_q     <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_msie_q     <= mie_msie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mscratch_q     <= mscratch_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule
